// File: rtl/position_calc_scheduler.sv
// position_calc_scheduler
// Shares one position-divider pipeline among the TBT, FA and SA magnitude
// sources: toggle edges become pending requests, one source is granted at a
// time, its magnitudes are latched, and X/Y/Q operand beats are issued over a
// valid/ready handshake after the operand pipeline has filled.
// Build macro POSCALC_SCHED_STARVE_EN adds per-source age counters so that a
// source left waiting STARVE_LIMIT grants outranks the fixed TBT > FA > SA order.
module position_calc_scheduler #(
    parameter int unsigned MAG_WIDTH    = 24,
    parameter int unsigned FILL_CYCLES  = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tbtInToggle,
    input  logic                   faInToggle,
    input  logic                   saInToggle,
    input  logic [4*MAG_WIDTH-1:0] tbtMags,
    input  logic [4*MAG_WIDTH-1:0] faMags,
    input  logic [4*MAG_WIDTH-1:0] saMags,
    input  logic                   overrunClear,
    output logic [4*MAG_WIDTH-1:0] magsOut,
    output logic [1:0]             sourceSelect,
    output logic [1:0]             operandSelect,
    output logic                   opValid,
    input  logic                   opReady,
    output logic [1:0]             opIndex,
    output logic                   busy,
    output logic                   overrun,
    output logic [47:0]            overrunCounts
);
    localparam int unsigned MW4       = 4 * MAG_WIDTH;
    localparam logic [2:0]  FILL_LAST = 3'(FILL_CYCLES - 1);

    if (FILL_CYCLES < 1 || FILL_CYCLES > 7 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("position_calc_scheduler: FILL_CYCLES must be 1..7 and STARVE_LIMIT 1..15");
    end

    typedef enum logic [1:0] {IDLE, LOAD, FILL, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        toggle_in, toggle_q, edge_det;
    logic [2:0]        pending_q, pending_d, cand, grant;
    logic [1:0]        grant_idx;
    logic [MW4-1:0]    mags_q, mags_d;
    logic [1:0]        src_q, src_d, opsel_q, opsel_d, opidx_q, opidx_d;
    logic              opvalid_q, opvalid_d;
    logic [2:0]        fill_q, fill_d;
    logic [2:0][15:0]  cnt_q, cnt_d;
    logic              overrun_q, overrun_d;

    // Bit order everywhere: [0]=TBT, [1]=FA, [2]=SA
    assign toggle_in = {saInToggle, faInToggle, tbtInToggle};
    assign edge_det  = toggle_in ^ toggle_q;

`ifdef POSCALC_SCHED_STARVE_EN
    localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT);

    logic [2:0][3:0] age_q, age_d;
    logic [2:0]      starved;

    // Aged pending sources replace the whole candidate set when any exist
    always_comb begin
        starved = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            starved[s] = pending_q[s] && (age_q[s] >= AGE_LIMIT);
        end
        cand = (starved != '0) ? starved : pending_q;
    end

    // Age grows for each source still waiting when another one is granted
    always_comb begin
        age_d = age_q;
        for (int unsigned s = 0; s < 3; s++) begin
            if (grant[s]) begin
                age_d[s] = '0;
            end else if ((grant != '0) && pending_q[s] && (age_q[s] != 4'hF)) begin
                age_d[s] = age_q[s] + 4'd1;
            end
        end
    end

    // Age counter register
    always_ff @(posedge clk) begin
        if (reset) age_q <= '0;
        else       age_q <= age_d;
    end
`else
    assign cand = pending_q;
`endif

    // Fixed-priority pick over the candidate set, only while idle
    always_comb begin
        grant     = '0;
        grant_idx = 2'd0;
        if (state_q == IDLE) begin
            if (cand[0]) begin
                grant = 3'b001; grant_idx = 2'd0;
            end else if (cand[1]) begin
                grant = 3'b010; grant_idx = 2'd1;
            end else if (cand[2]) begin
                grant = 3'b100; grant_idx = 2'd2;
            end
        end
    end

    // Request bookkeeping: an edge on a granted source re-arms it, an edge on a
    // source already waiting is an overrun
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        for (int unsigned s = 0; s < 3; s++) begin
            pending_d[s] = grant[s] ? edge_det[s] : (pending_q[s] | edge_det[s]);
            if (edge_det[s] && pending_q[s] && !grant[s]) begin
                overrun_d = 1'b1;
                if (cnt_q[s] != 16'hFFFF) cnt_d[s] = cnt_q[s] + 16'd1;
            end
        end
        if (overrunClear) begin
            cnt_d     = '0;
            overrun_d = 1'b0;
        end
    end

    // Job sequencer: grant -> LOAD -> FILL (FILL_CYCLES) -> ISSUE three beats
    always_comb begin
        state_d   = state_q;
        mags_d    = mags_q;
        src_d     = src_q;
        opsel_d   = opsel_q;
        opidx_d   = opidx_q;
        opvalid_d = opvalid_q;
        fill_d    = fill_q;
        unique case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    state_d = LOAD;
                    src_d   = grant_idx;
                    opsel_d = 2'd0;
                    unique case (grant_idx)
                        2'd0:    mags_d = tbtMags;
                        2'd1:    mags_d = faMags;
                        default: mags_d = saMags;
                    endcase
                end
            end
            LOAD: begin
                state_d = FILL;
                fill_d  = '0;
                opsel_d = 2'd1;
            end
            FILL: begin
                if (opsel_q != 2'd2) opsel_d = opsel_q + 2'd1;
                if (fill_q == FILL_LAST) begin
                    state_d   = ISSUE;
                    opvalid_d = 1'b1;
                    opidx_d   = 2'd0;
                end else begin
                    fill_d = fill_q + 3'd1;
                end
            end
            ISSUE: begin
                if (opReady) begin
                    if (opidx_q == 2'd2) begin
                        state_d   = IDLE;
                        opvalid_d = 1'b0;
                        opidx_d   = 2'd0;
                    end else begin
                        opidx_d = opidx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset reloads toggle history so release raises no request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            toggle_q  <= toggle_in;
            pending_q <= '0;
            mags_q    <= '0;
            src_q     <= '0;
            opsel_q   <= '0;
            opidx_q   <= '0;
            opvalid_q <= 1'b0;
            fill_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            toggle_q  <= toggle_in;
            pending_q <= pending_d;
            mags_q    <= mags_d;
            src_q     <= src_d;
            opsel_q   <= opsel_d;
            opidx_q   <= opidx_d;
            opvalid_q <= opvalid_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign magsOut       = mags_q;
    assign sourceSelect  = src_q;
    assign operandSelect = opsel_q;
    assign opValid       = opvalid_q;
    assign opIndex       = opidx_q;
    assign busy          = (state_q != IDLE);
    assign overrun       = overrun_q;
    assign overrunCounts = cnt_q;

endmodule

// File: tb/tb_position_calc_scheduler.sv
// Bench for position_calc_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a job-timeline reference model.
module tb_position_calc_scheduler;
    localparam int MW = 24;
    localparam int FC = 3;
    localparam int SL = 2;
    localparam int BW = 4 * MW;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    tog   = '0;
    logic [BW-1:0] mags [3];
    logic          clr   = 1'b0;
    logic          rdy   = 1'b1;

    logic [BW-1:0] magsOut;
    logic [1:0]    sourceSelect, operandSelect, opIndex;
    logic          opValid, busy, overrun;
    logic [47:0]   overrunCounts;

    always #5 clk = ~clk;

    position_calc_scheduler #(
        .MAG_WIDTH    (MW),
        .FILL_CYCLES  (FC),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tbtInToggle   (tog[0]),
        .faInToggle    (tog[1]),
        .saInToggle    (tog[2]),
        .tbtMags       (mags[0]),
        .faMags        (mags[1]),
        .saMags        (mags[2]),
        .overrunClear  (clr),
        .magsOut       (magsOut),
        .sourceSelect  (sourceSelect),
        .operandSelect (operandSelect),
        .opValid       (opValid),
        .opReady       (rdy),
        .opIndex       (opIndex),
        .busy          (busy),
        .overrun       (overrun),
        .overrunCounts (overrunCounts)
    );

    // Reference model: requests as flags, a job as "cycles since grant" plus beats done
    logic [2:0]    m_prev = '0, m_pend = '0;
    int            m_age [3];
    int            m_cnt [3];
    bit            m_ovf = 0, m_active = 0;
    int            m_t = 0, m_beats = 0, m_src = 0, m_opsel = 0, m_grant = -1;
    logic [BW-1:0] m_mags = '0;

    int ncmp = 0;
    int nerr = 0;
    int jobs [$];
    bit pb = 0;

    function automatic bit exp_valid();
        return m_active && (m_t >= 1 + FC);
    endfunction

    function automatic int pick();
`ifdef POSCALC_SCHED_STARVE_EN
        for (int s = 0; s < 3; s++) if (m_pend[s] && m_age[s] >= SL) return s;
`endif
        for (int s = 0; s < 3; s++) if (m_pend[s]) return s;
        return -1;
    endfunction

    task automatic model_step();
        logic [2:0] e;
        int g;
        if (reset) begin
            m_prev = tog; m_pend = '0;
            for (int s = 0; s < 3; s++) begin m_age[s] = 0; m_cnt[s] = 0; end
            m_ovf = 0; m_active = 0; m_t = 0; m_beats = 0; m_src = 0; m_opsel = 0;
            m_mags = '0; m_grant = -1;
            return;
        end
        e = tog ^ m_prev;
        m_prev = tog;
        g = m_active ? -1 : pick();
        if (m_active) begin
            if (exp_valid() && rdy) begin
                m_beats++;
                if (m_beats == 3) m_active = 0;
            end
            if (m_active) begin
                m_t++;
                m_opsel = (m_t >= 2) ? 2 : m_t;
            end
        end
        for (int s = 0; s < 3; s++) begin
            if (e[s] && m_pend[s] && g != s) begin
                if (m_cnt[s] < 65535) m_cnt[s]++;
                m_ovf = 1;
            end
        end
        if (clr) begin
            for (int s = 0; s < 3; s++) m_cnt[s] = 0;
            m_ovf = 0;
        end
`ifdef POSCALC_SCHED_STARVE_EN
        if (g >= 0) begin
            for (int s = 0; s < 3; s++) begin
                if (s == g) m_age[s] = 0;
                else if (m_pend[s] && m_age[s] < 15) m_age[s]++;
            end
        end
`endif
        for (int s = 0; s < 3; s++) m_pend[s] = (s == g) ? e[s] : (m_pend[s] | e[s]);
        if (g >= 0) begin
            m_active = 1; m_t = 0; m_beats = 0; m_src = g; m_opsel = 0; m_mags = mags[g];
        end
        m_grant = g;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("busy",          BW'(busy),          BW'(m_active));
        chk("opValid",       BW'(opValid),       BW'(exp_valid()));
        chk("opIndex",       BW'(opIndex),       BW'(exp_valid() ? m_beats : 0));
        chk("sourceSelect",  BW'(sourceSelect),  BW'(m_src));
        chk("operandSelect", BW'(operandSelect), BW'(m_opsel));
        chk("magsOut",       magsOut,            m_mags);
        chk("overrun",       BW'(overrun),       BW'(m_ovf));
        chk("overrunCounts", BW'(overrunCounts),
            BW'({16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])}));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic step_rec();
        step();
        if (busy && !pb) jobs.push_back(int'(sourceSelect));
        pb = busy;
    endtask

    task automatic flip(input int s);
        tog[s]  = ~tog[s];
        mags[s] = BW'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (!m_active && m_pend == '0) break;
            step();
        end
        chk("drain_idle", BW'(busy), '0);
    endtask

    task automatic run_to_beat1();
        for (int i = 0; i < 40; i++) begin
            if (exp_valid() && m_beats == 1) break;
            step();
        end
        chk("reach_beatY", BW'(opIndex), BW'(1));
    endtask

    initial begin
        int lat;
        int nsa;
        for (int s = 0; s < 3; s++) begin
            mags[s] = BW'({$urandom(), $urandom(), $urandom()});
            m_age[s] = 0; m_cnt[s] = 0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // Single FA toggle: latency, beats, source and magnitudes
        rdy = 1'b1;
        flip(1);
        step();
        lat = 0;
        while (opValid !== 1'b1 && lat < 20) begin step(); lat++; end
        chk("latency", BW'(lat), BW'(2 + FC));
        chk("fa_source", BW'(sourceSelect), BW'(1));
        chk("fa_mags", magsOut, mags[1]);
        drain();

        // All three sources in one cycle: served TBT, FA, SA with no overrun
        jobs.delete(); pb = busy;
        flip(0); flip(1); flip(2);
        for (int i = 0; i < 40; i++) step_rec();
        chk("order_count", BW'(jobs.size()), BW'(3));
        if (jobs.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("order_src", BW'(jobs[k]), BW'(k));
        end
        chk("order_no_overrun", BW'(overrun), '0);
        drain();

        // Stall on beat Y for four cycles
        flip(0);
        run_to_beat1();
        rdy = 1'b0;
        repeat (4) step();
        rdy = 1'b1;
        step();
        chk("stall_q_index", BW'(opIndex), BW'(2));
        chk("stall_q_valid", BW'(opValid), BW'(1));
        drain();

        // TBT toggles three times during a stalled SA job, then clear
        rdy = 1'b0;
        flip(2);
        for (int i = 0; i < 20; i++) begin
            if (exp_valid()) break;
            step();
        end
        for (int k = 0; k < 3; k++) begin flip(0); step(); step(); end
        chk("ovr_tbt_count", BW'(overrunCounts[15:0]), BW'(2));
        chk("ovr_sticky", BW'(overrun), BW'(1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovr_cleared", BW'(overrunCounts), '0);
        chk("ovr_flag_cleared", BW'(overrun), '0);
        rdy = 1'b1;
        drain();

        // TBT re-requested after each of its grants while SA waits
        jobs.delete(); pb = busy;
        flip(0); flip(2);
        for (int i = 0; i < 120 && jobs.size() < 4; i++) begin
            if (m_grant == 0) flip(0);
            step_rec();
        end
        chk("starve_jobs", BW'(jobs.size() >= 3), BW'(1));
`ifdef POSCALC_SCHED_STARVE_EN
        if (jobs.size() >= 3) chk("starve_sa_third", BW'(jobs[2]), BW'(2));
`else
        nsa = 0;
        foreach (jobs[k]) if (jobs[k] == 2) nsa++;
        chk("starve_sa_never", BW'(nsa), '0);
`endif
        drain();

        // Reset in the middle of ISSUE, then no spurious request
        flip(1);
        run_to_beat1();
        reset = 1'b1;
        step();
        chk("rst_opvalid", BW'(opValid), '0);
        chk("rst_busy", BW'(busy), '0);
        reset = 1'b0;
        repeat (8) step();
        chk("rst_no_request", BW'(busy), '0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int s = 0; s < 3; s++) if ($urandom_range(0, 11) == 0) flip(s);
            rdy   = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; clr = 1'b0; rdy = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
